servo_bank: RTL and testbench

- Parametrised N-channel hobby-servo controller; next generation of the fixed 4-servo key-stepped angle block.
- Takes the keypad command code plus an absolute-set command port, and holds a saturating target angle per channel.
- Slews each channel's current angle toward its target at one degree per PWM frame.
- Generates one glitch-free PWM output per channel, with pulse width latched at frame boundaries.

---
 rtl/servo_bank_if.sv | 25 ++
 rtl/servo_bank.sv | 159 +++++++++++++++
 tb/tb_servo_bank.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_bank_if.sv
// Command and status bundle for the servo bank: keypad/absolute-set inputs,
// PWM outputs and angle telemetry.
interface servo_bank_if #(
   parameter int NCH     = 4,
   parameter int ANGLE_W = 8
);
   logic [7:0]             key;
   logic                   cmd_valid;
   logic [3:0]             cmd_ch;
   logic [ANGLE_W-1:0]     cmd_angle;
   logic [NCH-1:0]         pwm;
   logic                   frame_start;
   logic                   busy;
   logic [NCH*ANGLE_W-1:0] cur_angle;

   modport master (
      output key, cmd_valid, cmd_ch, cmd_angle,
      input  pwm, frame_start, busy, cur_angle
   );

   modport slave (
      input  key, cmd_valid, cmd_ch, cmd_angle,
      output pwm, frame_start, busy, cur_angle
   );
endinterface

// File: rtl/servo_bank.sv
// N-channel hobby-servo controller: saturating per-channel targets, one-degree
// per frame slew, and frame-latched glitch-free PWM.
module servo_bank #(
   parameter int NCH            = 4,
   parameter int ANGLE_W        = 8,
   parameter int ANG_MIN        = 10,
   parameter int ANG_MAX        = 170,
   parameter int ANG_INIT       = 90,
   parameter int STEP           = 5,
   parameter int KEY_BASE       = 6,
   parameter int PWM_PERIOD_CYC = 1000000,
   parameter int PULSE_MIN_CYC  = 25000,
   parameter int CYC_PER_DEG    = 278
) (
   input  logic        clk,
   input  logic        rst_n,
   servo_bank_if.slave bus
);

   localparam int CNT_W = $clog2(PWM_PERIOD_CYC);
   localparam int AW1   = ANGLE_W + 1;

   localparam logic [AW1-1:0]     W_MIN      = AW1'(ANG_MIN);
   localparam logic [AW1-1:0]     W_MAX      = AW1'(ANG_MAX);
   localparam logic [AW1-1:0]     W_STEP     = AW1'(STEP);
   localparam logic [ANGLE_W-1:0] A_MIN      = ANGLE_W'(ANG_MIN);
   localparam logic [ANGLE_W-1:0] A_MAX      = ANGLE_W'(ANG_MAX);
   localparam logic [ANGLE_W-1:0] A_INIT     = ANGLE_W'(ANG_INIT);
   localparam logic [CNT_W-1:0]   C_PMIN     = CNT_W'(PULSE_MIN_CYC);
   localparam logic [CNT_W-1:0]   C_CPD      = CNT_W'(CYC_PER_DEG);
   localparam logic [CNT_W-1:0]   C_LAST     = CNT_W'(PWM_PERIOD_CYC - 1);
   localparam logic [CNT_W-1:0]   C_LAT_INIT = CNT_W'(PULSE_MIN_CYC + ANG_INIT * CYC_PER_DEG);

   // The widest pulse must end before the frame does, or PWM would never fall.
   generate
      if (PULSE_MIN_CYC + ANG_MAX * CYC_PER_DEG >= PWM_PERIOD_CYC) begin : g_bad_timing
         $error("servo_bank: widest pulse does not fit inside the PWM frame");
      end
      if (NCH < 1 || NCH > 16) begin : g_bad_nch
         $error("servo_bank: NCH must be within 1..16");
      end
   endgenerate

   logic [CNT_W-1:0]   r_cnt;
   logic               r_frameStart;
   logic [7:0]         r_keyQ;
   logic [ANGLE_W-1:0] r_tgt [NCH];
   logic [ANGLE_W-1:0] r_cur [NCH];
   logic [CNT_W-1:0]   r_lat [NCH];
   logic [NCH-1:0]     r_pwm;
   logic               r_busy;

   logic               w_wrap;
   logic               w_keyInRange;
   logic               w_keyEvent;
   logic [7:0]         w_keyOff;
   logic [3:0]         w_keyCh;
   logic               w_keyDec;
   logic [ANGLE_W-1:0] w_tgtNext [NCH];
   logic [NCH-1:0]     w_diff;

   function automatic logic [ANGLE_W-1:0] incAngle(input logic [ANGLE_W-1:0] a);
      logic [AW1-1:0] s;
      s = {1'b0, a} + W_STEP;
      return (s >= W_MAX) ? A_MAX : ANGLE_W'(s);
   endfunction

   function automatic logic [ANGLE_W-1:0] decAngle(input logic [ANGLE_W-1:0] a);
      logic [AW1-1:0] e;
      e = {1'b0, a};
      return (e <= W_MIN + W_STEP) ? A_MIN : ANGLE_W'(e - W_STEP);
   endfunction

   function automatic logic [ANGLE_W-1:0] clampAngle(input logic [ANGLE_W-1:0] a);
      if (a < A_MIN) return A_MIN;
      if (a > A_MAX) return A_MAX;
      return a;
   endfunction

   assign w_wrap = (r_cnt == C_LAST);

   // A key acts only on the cycle its code changes, so a held key steps once.
   assign w_keyInRange = (int'(bus.key) >= KEY_BASE) && (int'(bus.key) < KEY_BASE + 2 * NCH);
   assign w_keyEvent   = (bus.key != r_keyQ) && w_keyInRange;
   assign w_keyOff     = bus.key - 8'(KEY_BASE);
   assign w_keyCh      = 4'(w_keyOff >> 1);
   assign w_keyDec     = w_keyOff[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_frameStart <= 1'b0;
         r_keyQ       <= '0;
      end else begin
         r_cnt        <= w_wrap ? '0 : r_cnt + CNT_W'(1);
         r_frameStart <= (r_cnt == '0);
         r_keyQ       <= bus.key;
      end
   end

   // An absolute set beats a key event aimed at the same channel.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         w_tgtNext[i] = r_tgt[i];
         if (bus.cmd_valid && (bus.cmd_ch == 4'(i))) begin
            w_tgtNext[i] = clampAngle(bus.cmd_angle);
         end else if (w_keyEvent && (w_keyCh == 4'(i))) begin
            w_tgtNext[i] = w_keyDec ? decAngle(r_tgt[i]) : incAngle(r_tgt[i]);
         end
      end
   end

   always_comb begin
      w_diff = '0;
      for (int i = 0; i < NCH; i++) begin
         w_diff[i] = (r_cur[i] != r_tgt[i]);
      end
   end

   // Pulse widths latch from the pre-slew angle at the wrap, so a pulse in
   // flight is never reshaped by a target or angle change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCH; i++) begin
            r_tgt[i] <= A_INIT;
            r_cur[i] <= A_INIT;
            r_lat[i] <= C_LAT_INIT;
         end
         r_pwm  <= '0;
         r_busy <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            r_tgt[i] <= w_tgtNext[i];
            if (w_wrap) begin
               r_lat[i] <= C_PMIN + CNT_W'(r_cur[i]) * C_CPD;
               if (r_cur[i] < r_tgt[i]) begin
                  r_cur[i] <= r_cur[i] + ANGLE_W'(1);
               end else if (r_cur[i] > r_tgt[i]) begin
                  r_cur[i] <= r_cur[i] - ANGLE_W'(1);
               end
            end
            r_pwm[i] <= (r_cnt < r_lat[i]);
         end
         r_busy <= |w_diff;
      end
   end

   assign bus.pwm         = r_pwm;
   assign bus.frame_start = r_frameStart;
   assign bus.busy        = r_busy;

   genvar g;
   generate
      for (g = 0; g < NCH; g++) begin : g_pack
         assign bus.cur_angle[g*ANGLE_W +: ANGLE_W] = r_cur[g];
      end
   endgenerate

endmodule

// File: tb/tb_servo_bank.sv
// Scoreboard bench for servo_bank: a reference model pushes expected targets
// and pulse widths, which are popped as the DUT produces them.
module tb_servo_bank;

   localparam int NCH     = 4;
   localparam int ANGLE_W = 8;
   localparam int PERIOD  = 2000;
   localparam int PMIN    = 50;
   localparam int CPD     = 2;
   localparam int AMIN    = 10;
   localparam int AMAX    = 170;
   localparam int AINIT   = 90;
   localparam int STEP    = 5;
   localparam int KBASE   = 6;

   typedef struct {
      int ch;
      int val;
   } tgtExp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   servo_bank_if #(.NCH(NCH), .ANGLE_W(ANGLE_W)) bus ();

   servo_bank #(
      .NCH(NCH),
      .ANGLE_W(ANGLE_W),
      .PWM_PERIOD_CYC(PERIOD),
      .PULSE_MIN_CYC(PMIN),
      .CYC_PER_DEG(CPD)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         failed = 0;
   int         mTgt [NCH];
   int         mCur [NCH];
   int         mCnt;
   logic [7:0] mKeyQ;
   int         qPulse [NCH][$];
   tgtExp_t    qTgt [$];
   int         run [NCH];
   logic [NCH-1:0] prevPwm;
   bit         lastExpBusy;
   bit         lastObsBusy;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      tests++;
      if (observed != expected) begin
         failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int incT(input int t);
      return (t + STEP >= AMAX) ? AMAX : t + STEP;
   endfunction

   function automatic int decT(input int t);
      return (t <= AMIN + STEP) ? AMIN : t - STEP;
   endfunction

   function automatic int clampT(input int a);
      if (a < AMIN) return AMIN;
      if (a > AMAX) return AMAX;
      return a;
   endfunction

   function automatic int curA(input int i);
      return int'(bus.cur_angle[i*ANGLE_W +: ANGLE_W]);
   endfunction

   task automatic resetModel();
      for (int i = 0; i < NCH; i++) begin
         mTgt[i] = AINIT;
         mCur[i] = AINIT;
         qPulse[i].delete();
         qPulse[i].push_back(PMIN + AINIT * CPD);
         run[i] = 0;
      end
      mCnt        = 0;
      mKeyQ       = '0;
      qTgt.delete();
      prevPwm     = '0;
      lastExpBusy = 1'b0;
      lastObsBusy = 1'b0;
   endtask

   // One clock of the reference model plus scoreboard pops after the edge.
   task automatic tick();
      int      newTgt [NCH];
      int      off;
      int      expW;
      bit      evt;
      bit      wrap;
      bit      expFs;
      bit      expBusy;
      tgtExp_t e;

      newTgt = mTgt;
      off    = int'(bus.key) - KBASE;
      evt    = (bus.key != mKeyQ) && (off >= 0) && (off < 2 * NCH);
      if (bus.cmd_valid && int'(bus.cmd_ch) < NCH)
         newTgt[bus.cmd_ch] = clampT(int'(bus.cmd_angle));
      if (evt && !(bus.cmd_valid && int'(bus.cmd_ch) == off / 2))
         newTgt[off/2] = (off % 2 == 1) ? decT(mTgt[off/2]) : incT(mTgt[off/2]);
      if (bus.cmd_valid || evt) begin
         for (int i = 0; i < NCH; i++) begin
            e.ch  = i;
            e.val = newTgt[i];
            qTgt.push_back(e);
         end
      end
      wrap    = (mCnt == PERIOD - 1);
      expFs   = (mCnt == 0);
      expBusy = 1'b0;
      for (int i = 0; i < NCH; i++)
         if (mCur[i] != mTgt[i]) expBusy = 1'b1;

      @(posedge clk);
      #1;

      if (wrap) begin
         for (int i = 0; i < NCH; i++) begin
            qPulse[i].push_back(PMIN + mCur[i] * CPD);
            if (mCur[i] < mTgt[i]) mCur[i]++;
            else if (mCur[i] > mTgt[i]) mCur[i]--;
            checkOutput($sformatf("cur%0d", i), curA(i), mCur[i]);
         end
      end
      mTgt  = newTgt;
      mKeyQ = bus.key;
      mCnt  = (mCnt + 1) % PERIOD;

      while (qTgt.size() > 0) begin
         e = qTgt.pop_front();
         checkOutput($sformatf("tgt%0d", e.ch), int'(dut.r_tgt[e.ch]), e.val);
      end

      if (expFs || bus.frame_start)
         checkOutput("frame_start", int'(bus.frame_start), int'(expFs));

      if (expBusy != lastExpBusy || bus.busy != lastObsBusy)
         checkOutput("busy", int'(bus.busy), int'(expBusy));
      lastExpBusy = expBusy;
      lastObsBusy = bus.busy;

      for (int i = 0; i < NCH; i++) begin
         if (bus.pwm[i]) begin
            if (!prevPwm[i])
               checkOutput($sformatf("pwm%0d_rise_fs", i), int'(bus.frame_start), 1);
            run[i]++;
         end else if (prevPwm[i]) begin
            expW = (qPulse[i].size() > 0) ? qPulse[i].pop_front() : -1;
            checkOutput($sformatf("pulse%0d", i), run[i], expW);
            run[i] = 0;
         end
      end
      prevPwm = bus.pwm;
   endtask

   task automatic applyStimulus(input logic [7:0] k, input bit v, input int ch, input int ang);
      bus.key       = k;
      bus.cmd_valid = v;
      bus.cmd_ch    = 4'(ch);
      bus.cmd_angle = ANGLE_W'(ang);
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic press(input logic [7:0] k);
      applyStimulus(k, 1'b0, 0, 0);
      applyStimulus(8'd0, 1'b0, 0, 0);
   endtask

   task automatic checkResetState();
      checkOutput("rst_pwm", int'(bus.pwm), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_frame_start", int'(bus.frame_start), 0);
      for (int i = 0; i < NCH; i++)
         checkOutput($sformatf("rst_cur%0d", i), curA(i), AINIT);
   endtask

   initial begin
      int n;
      bus.key       = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_ch    = '0;
      bus.cmd_angle = '0;
      resetModel();
      repeat (3) @(negedge clk);
      checkResetState();
      rst_n = 1'b1;

      $display("[TB] reset and idle frames");
      repeat (2 * PERIOD + 1) tick();

      $display("[TB] held key steps once, slew to 95");
      bus.key = 8'd6;
      repeat (100) tick();
      bus.key = 8'd0;
      n = 0;
      while ((curA(0) != 95 || bus.busy) && n < 8 * PERIOD) begin
         tick();
         n++;
      end
      checkOutput("settle_in_budget", int'(n < 8 * PERIOD), 1);
      checkOutput("settle_cur0", curA(0), 95);
      repeat (PERIOD) tick();

      $display("[TB] key saturation");
      repeat (17) press(8'd6);
      applyStimulus(8'd0, 1'b1, 0, 12);
      repeat (7) press(8'd7);
      repeat (17) press(8'd12);
      applyStimulus(8'd0, 1'b1, 3, 12);
      repeat (7) press(8'd13);

      $display("[TB] absolute set clamp and ignore");
      applyStimulus(8'd0, 1'b1, 2, 200);
      applyStimulus(8'd0, 1'b1, 2, 3);
      applyStimulus(8'd0, 1'b1, 5, 77);

      $display("[TB] simultaneous cmd and key");
      applyStimulus(8'd0, 1'b1, 2, 90);
      applyStimulus(8'd8, 1'b1, 1, 40);
      applyStimulus(8'd0, 1'b0, 0, 0);
      applyStimulus(8'd10, 1'b1, 1, 40);
      applyStimulus(8'd0, 1'b0, 0, 0);

      $display("[TB] mid-frame retarget and mid-pulse reset");
      n = 0;
      while (mCnt != 1000 && n < PERIOD) begin
         tick();
         n++;
      end
      applyStimulus(8'd0, 1'b1, 0, 120);
      repeat (2 * PERIOD) tick();
      n = 0;
      while (mCnt != 20 && n < PERIOD) begin
         tick();
         n++;
      end
      checkOutput("pre_rst_pwm", int'(bus.pwm), 'hF);
      rst_n = 1'b0;
      #1;
      checkResetState();
      resetModel();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (PERIOD + 300) tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
